pp_stream_merge: RTL
====================

Name: pp_stream_merge

Overview:
- Downstream consumer of the ping-pong buffer.
- Takes the two bank read ports (douta_b / doutb_b) plus the read-bank select and valid, and merges them back into one continuous sample stream.
- Packs PACK consecutive samples into a wide word and buffers the words in a small FIFO behind a valid/ready handshake.
- Checks stream continuity: expects incrementing data modulo 2^DW, counts errors and bank swaps.

Parameters:
- DW, 4: width of one sample (bank read data width).
- PACK, 4: samples per output word; power of 2, at least 2.
- FIFO_DEPTH, 4: output FIFO entries; power of 2.
- CNT_W, 16: width of the status counters.

Ports:
- clk_100  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous clear of packer, FIFO, checker and counters.
- douta_b  in  DW  bank A read data, valid when rd_vld=1 and rd_sel=0.
- doutb_b  in  DW  bank B read data, valid when rd_vld=1 and rd_sel=1.
- rd_sel  in  1  bank currently being read (0=A, 1=B).
- rd_vld  in  1  read data valid this cycle; already aligned to the RAM read latency.
- m_data  out  DW*PACK  packed output word; first sample in the LSBs.
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts m_data when m_valid and m_ready are both 1.
- err_cnt  out  CNT_W  continuity errors; saturates at all-ones.
- swap_cnt  out  CNT_W  bank switches between consecutive valid samples; saturates.
- ovf  out  1  sticky; set when a completed word is dropped because the FIFO is full.

Behaviour:
- Reset (rst_n=0, acts immediately):
  - m_valid=0, m_data=0, err_cnt=0, swap_cnt=0, ovf=0.
  - FIFO empty, packer slot=0, checker unseeded, last_sel=0.
- Sample selection: s = rd_sel ? doutb_b : douta_b, taken only when rd_vld=1. When rd_vld=0, no state changes except FIFO pop.
- Packer:
  - Slot counter 0..PACK-1; sample written to bits [slot*DW +: DW].
  - When slot PACK-1 is filled, the complete word (held slots plus the incoming sample) is pushed to the FIFO on that same edge, and slot returns to 0.
  - Latency: m_valid rises on the cycle after the edge that captured the last sample, if the FIFO was empty.
- FIFO:
  - Show-ahead: m_data always equals the head entry; m_data=0 when empty.
  - Pop on m_valid and m_ready.
  - Push while full with a pop in the same cycle: accepted, count unchanged.
  - Push while full with no pop: word dropped, ovf=1 (sticky until reset or clr); packer still restarts at slot 0.
  - Upstream is never back-pressured.
- Checker:
  - First valid sample after reset or clr seeds expect = s+1 (mod 2^DW); no error is counted.
  - Each later valid sample: if s != expect, err_cnt increments (saturating).
  - In either case expect is then set to s+1, so the checker resynchronises.
  - Wrap from all-ones to 0 is not an error.
- Swap counter:
  - On a valid sample with the checker already seeded, if rd_sel != last_sel, swap_cnt increments (saturating).
  - last_sel updates on every valid sample.
  - A swap does not affect packing alignment.
- clr:
  - Single-cycle synchronous clear: slot=0, FIFO flushed (m_valid=0 next cycle), counters=0, ovf=0, checker unseeded.
  - Takes priority over rd_vld and pop in the same cycle; that sample is discarded.
- Reset mid-word: the partial word is lost. After rst_n release, the first valid sample starts a fresh word at slot 0.

Decomposition:
- Shared package pp_pkg holds:
  - default DW / PACK constants shared with the ping_pong block;
  - a clog2-style function for slot and FIFO pointer widths;
  - the bank-select encoding constants BANK_A=0, BANK_B=1.
- One sub-module: pp_sync_fifo (parameters: width, depth), with push, pop, full, empty, show-ahead read data and async active-low reset.
- Packer, checker and counters live in pp_stream_merge.

Test Plan:
- Continuity, no stalls:
  - Stimulus: samples 0..7 on bank A then 8..F on bank B, rd_vld every cycle, m_ready=1.
  - Response: m_data = 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC; err_cnt=0; swap_cnt=1.
- Wrap-around:
  - Stimulus: E, F, 0, 1.
  - Response: m_data = 16'h10FE; err_cnt=0.
- Discontinuity:
  - Stimulus: 0, 1, 2, 5, 6, 7, 8, 9.
  - Response: err_cnt=1 after sample 5, stays 1; words 16'h5210 and 16'h9876.
- Backpressure:
  - Stimulus: m_ready=0, 20 consecutive samples 0..3 repeating per word.
  - Response: 4 words stored, 5th dropped, ovf=1.
  - Then m_ready=1: 4 words of 16'h3210 drain one per cycle, then m_valid=0, ovf stays 1.
- Async reset mid-word:
  - Stimulus: 2 samples, then pull rst_n low between clock edges.
  - Response: m_valid, err_cnt, swap_cnt, ovf go 0 without waiting for a clock edge.
  - After release, samples 4, 5, 6, 7 give m_data = 16'h7654, err_cnt=0.
- clr with rd_vld in the same cycle:
  - Stimulus: clr=1 while rd_vld=1 on a sample.
  - Response: that sample is discarded, counters and ovf are 0, FIFO is empty.
  - The next sample seeds the checker with no error and lands in slot 0.

Source files
------------

// File: rtl/pp_pkg.sv
// Constants and helpers shared between the ping-pong buffer and its stream consumer.
package pp_pkg;
  localparam int PP_DW   = 4;
  localparam int PP_PACK = 4;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Bits needed to index n entries; never less than one so a 1-entry index stays legal.
  function automatic int pp_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/pp_sync_fifo.sv
// Show-ahead synchronous FIFO; rdata reads as zero while empty.
module pp_sync_fifo
  import pp_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = pp_clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pp_stream_merge.sv
// Merges the two ping-pong bank read ports into one stream, packs PACK samples per word,
// queues words behind valid/ready and checks that the stream increments by one.
module pp_stream_merge
  import pp_pkg::*;
#(
  parameter int DW         = PP_DW,
  parameter int PACK       = PP_PACK,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk_100,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [DW-1:0]      douta_b,
  input  logic [DW-1:0]      doutb_b,
  input  logic               rd_sel,
  input  logic               rd_vld,
  output logic [DW*PACK-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   swap_cnt,
  output logic               ovf
);
  localparam int SW = pp_clog2(PACK);

  logic [DW-1:0]             s;
  logic                      take, last_slot, push, pop, full, empty;
  logic [SW-1:0]             slot_q;
  logic [PACK-1:0][DW-1:0]   word_q, push_word;
  logic                      seeded_q, last_sel_q;
  logic [DW-1:0]             expect_q;

  assign s         = (rd_sel == BANK_B) ? doutb_b : douta_b;
  assign take      = rd_vld & ~clr;
  assign last_slot = (slot_q == SW'(PACK - 1));
  assign push      = take & last_slot;
  assign pop       = m_valid & m_ready;
  // The last sample bypasses its slot register and goes straight into the pushed word.
  assign push_word = {s, word_q[PACK-2:0]};
  assign m_valid   = ~empty;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n)                slot_q <= '0;
    else if (clr)              slot_q <= '0;
    else if (take)             slot_q <= last_slot ? '0 : slot_q + 1'b1;
  end

  for (genvar g = 0; g < PACK; g++) begin : g_slot
    always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n)                              word_q[g] <= '0;
      else if (take && slot_q == SW'(g))       word_q[g] <= s;
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      seeded_q   <= 1'b0;
      last_sel_q <= BANK_A;
      expect_q   <= '0;
      err_cnt    <= '0;
      swap_cnt   <= '0;
      ovf        <= 1'b0;
    end else if (clr) begin
      seeded_q   <= 1'b0;
      last_sel_q <= BANK_A;
      expect_q   <= '0;
      err_cnt    <= '0;
      swap_cnt   <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push && full && !pop) ovf <= 1'b1;
      if (take) begin
        seeded_q   <= 1'b1;
        last_sel_q <= rd_sel;
        expect_q   <= s + 1'b1;
        if (seeded_q) begin
          if (s != expect_q && ~&err_cnt)       err_cnt  <= err_cnt + 1'b1;
          if (rd_sel != last_sel_q && ~&swap_cnt) swap_cnt <= swap_cnt + 1'b1;
        end
      end
    end
  end

  pp_sync_fifo #(.W(DW*PACK), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_100),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (push_word),
    .rdata (m_data),
    .full  (full),
    .empty (empty)
  );
endmodule
